// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared definitions for the pipeline sequencer: address bus
//            width, zero word, stall vector width and encodings, FSM states.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Instruction address bus width and its all-zero value
    localparam int                        c_INST_ADDR_W = 32;
    localparam logic [c_INST_ADDR_W-1:0]  c_ZERO_WORD   = '0;

    // Stall vector: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold stage
    localparam int                        c_STALL_W     = 6;
    localparam logic [c_STALL_W-1:0]      c_STALL_NONE  = 6'b000000;
    localparam logic [c_STALL_W-1:0]      c_STALL_ID    = 6'b000111;
    localparam logic [c_STALL_W-1:0]      c_STALL_EX    = 6'b001111;
    localparam logic [c_STALL_W-1:0]      c_STALL_MEM   = 6'b011111;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_ctrl_stall_enc.sv
//==============================================================================
// Module   : pipe_ctrl_stall_enc
// Brief    : Combinational merge of per-stage stall requests into one stall
//            vector; the deepest requesting stage determines the pattern.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ctrl_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic                  stallreq_if,
    input  logic                  stallreq_id,
    input  logic                  stallreq_ex,
    input  logic                  stallreq_mem,
    output logic [c_STALL_W-1:0]  stall_enc,
    output logic                  any_req
);

    // Priority encode: MEM over EX over ID/IF (IF stalls like ID, holding PC..ID)
    always_comb begin
        stall_enc = c_STALL_NONE;
        if (stallreq_mem) begin
            stall_enc = c_STALL_MEM;
        end else if (stallreq_ex) begin
            stall_enc = c_STALL_EX;
        end else if (stallreq_id || stallreq_if) begin
            stall_enc = c_STALL_ID;
        end
    end

    assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

endmodule : pipe_ctrl_stall_enc

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline sequencer for the 5-stage core. Merges stage stall
//            requests into the stall vector, sequences multi-cycle flushes
//            with a redirect PC and counts stalled cycles.
//            Optional watchdog enabled by defining PIPE_CTRL_WDOG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = c_INST_ADDR_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_CYCLES  = 255
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallreq_if,
    input  logic                  stallreq_id,
    input  logic                  stallreq_ex,
    input  logic                  stallreq_mem,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     flush_pc_i,
    output logic [c_STALL_W-1:0]  stall_o,
    output logic                  flush_o,
    output logic [ADDR_W-1:0]     new_pc_o,
    output logic [31:0]           stall_cnt_o,
    output logic                  wdog_o
);

    // Flush counter only needs to reach FLUSH_CYCLES-1; keep at least one bit
    localparam int                c_FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FLUSH_CYCLES - 1);

    pipe_state_e            r_state;
    pipe_state_e            w_state_nxt;
    logic [c_FC_W-1:0]      r_flush_cnt;
    logic [ADDR_W-1:0]      r_new_pc;
    logic                   r_flush;
    logic [31:0]            r_stall_cnt;
    logic [c_STALL_W-1:0]   w_stall_enc;
    logic [c_STALL_W-1:0]   w_stall;
    logic                   w_any_req;
    logic                   w_flush_last;

    pipe_ctrl_stall_enc u_stall_enc (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall_enc    (w_stall_enc),
        .any_req      (w_any_req)
    );

    assign w_flush_last = (r_flush_cnt == c_FC_LAST);

    // Next-state and stall output; the stall vector is masked during reset and FLUSH
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = c_STALL_NONE;
        case (r_state)
            ST_RUN: begin
                w_stall = w_stall_enc;
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_any_req) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                w_stall = w_stall_enc;
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else if (!w_any_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_flush_last) begin
                    w_state_nxt = w_any_req ? ST_STALL : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (!rst) begin
            w_stall = c_STALL_NONE;
        end
    end

    // State register, flush strobe, redirect PC latch and flush length counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_flush     <= 1'b0;
            r_new_pc    <= ADDR_W'(c_ZERO_WORD);
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= (w_state_nxt == ST_FLUSH);
            if (flush_req) begin
                // A new request (even mid-flush) relatches the target and restarts the count
                r_new_pc    <= flush_pc_i;
                r_flush_cnt <= '0;
            end else if ((r_state == ST_FLUSH) && !w_flush_last) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Saturating count of cycles in which any stage is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if ((w_stall != c_STALL_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int                c_WD_W    = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WDOG_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog_cnt;
    logic              r_wdog;

    // Consecutive-stall watchdog; any unstalled cycle (including FLUSH) clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
            r_wdog     <= 1'b0;
        end else begin
            r_wdog <= 1'b0;
            if (w_stall == c_STALL_NONE) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt == c_WD_LAST) begin
                r_wdog_cnt <= '0;
                r_wdog     <= 1'b1;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
        end
    end

    assign wdog_o = r_wdog;
`else
    assign wdog_o = 1'b0;
`endif

    assign stall_o     = w_stall;
    assign flush_o     = r_flush;
    assign new_pc_o    = r_new_pc;
    assign stall_cnt_o = r_stall_cnt;

endmodule : pipe_ctrl

`default_nettype wire
